rv32_csr_uart: RTL and testbench



---
 rtl/rv32_csr_uart.sv | 159 +++++++++++++++
 tb/tb_rv32_csr_uart.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rv32_csr_uart.sv
// CSR-space responder for the rv32 core: 64-bit cycle counter, mscratch,
// and a TX FIFO feeding an 8N1 UART transmitter with a programmable bit period.
module rv32_csr_uart #(
  parameter logic [15:0] BAUD_DIV_RST = 16'd868,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [11:0] m_addr,
  input  logic [31:0] d_t_mem,
  input  logic        io_wrn,
  input  logic        io_rdn,
  output logic [31:0] d_f_mem,
  output logic        txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [11:0] A_CYCLE  = 12'hC00;
  localparam logic [11:0] A_CYCLEH = 12'hC80;
  localparam logic [11:0] A_SCR    = 12'h340;
  localparam logic [11:0] A_UDATA  = 12'h7C0;
  localparam logic [11:0] A_UDIV   = 12'h7C1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  logic [63:0] cycle_cnt;
  logic [31:0] mscratch;
  logic [15:0] div;
  logic        ovf;
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;

  tx_state_t   state;
  logic [15:0] bit_cnt, bit_div;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;

  logic        wr, fifo_empty, fifo_full, push_req, push, pop, bit_end;
  logic [15:0] div_eff;

  assign wr         = ~io_wrn;
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push_req   = wr && (m_addr == A_UDATA);
  assign push       = push_req && !fifo_full;
  assign div_eff    = (div == 16'd0) ? 16'd1 : div;
  // bit_div is latched at each bit start so a divisor write never stretches the current bit
  assign bit_end    = (bit_cnt == bit_div - 16'd1);
  assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));

  always_ff @(posedge clk) begin
    if (clr) begin
      cycle_cnt <= '0;
      mscratch  <= '0;
      div       <= BAUD_DIV_RST;
      ovf       <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (wr && (m_addr == A_SCR)) mscratch <= d_t_mem;
      if (wr && (m_addr == A_UDIV)) begin
        div <= d_t_mem[15:0];
        ovf <= 1'b0;
      end else if (push_req && fifo_full) begin
        ovf <= 1'b1;
      end
      if (push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) fifo_mem[wptr[AW-1:0]] <= d_t_mem[7:0];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      txd     <= 1'b1;
      bit_cnt <= '0;
      bit_div <= 16'd1;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift   <= fifo_mem[rptr[AW-1:0]];
            bit_div <= div_eff;
            bit_cnt <= '0;
            state   <= START;
            txd     <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_div <= div_eff;
            bit_idx <= '0;
            state   <= DATA;
            txd     <= shift[0];
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_div <= div_eff;
            shift   <= shift >> 1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_div <= div_eff;
            // back-to-back frames: next start bit follows the stop bit directly
            if (pop) begin
              shift <= fifo_mem[rptr[AW-1:0]];
              state <= START;
              txd   <= 1'b0;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    d_f_mem = '0;
    if (!io_rdn) begin
      case (m_addr)
        A_CYCLE:  d_f_mem = cycle_cnt[31:0];
        A_CYCLEH: d_f_mem = cycle_cnt[63:32];
        A_SCR:    d_f_mem = mscratch;
        A_UDATA:  d_f_mem = {28'd0, ovf, (state != IDLE), fifo_full, fifo_empty};
        A_UDIV:   d_f_mem = {16'd0, div};
        default:  d_f_mem = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32_csr_uart.sv
// Randomized self-checking bench for rv32_csr_uart against a frame-timing reference model.
module tb_rv32_csr_uart;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        clr, io_wrn, io_rdn, txd;
  logic [11:0] m_addr;
  logic [31:0] d_t_mem, d_f_mem;

  int n_checks = 0;
  int n_errors = 0;

  rv32_csr_uart #(.BAUD_DIV_RST(16'd868), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .m_addr(m_addr), .d_t_mem(d_t_mem),
    .io_wrn(io_wrn), .io_rdn(io_rdn), .d_f_mem(d_f_mem), .txd(txd)
  );

  always #5 clk = ~clk;

  // Reference model: frames are described by their start edge, byte and divisor
  logic [63:0] m_cnt;
  logic [31:0] m_scr;
  logic [15:0] m_div;
  logic        m_ovf, m_busy;
  logic [7:0]  q[$];
  logic [7:0]  m_byte;
  int          m_start, m_fdiv, ecount = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_txd();
    int b;
    if (!m_busy) return 1'b1;
    b = (ecount - m_start) / m_fdiv;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_rd(input logic [11:0] a);
    case (a)
      12'hC00: return m_cnt[31:0];
      12'hC80: return m_cnt[63:32];
      12'h340: return m_scr;
      12'h7C0: return {28'd0, m_ovf, m_busy, (q.size() == DEPTH), (q.size() == 0)};
      12'h7C1: return {16'd0, m_div};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    int pre_size;
    ecount++;
    if (clr) begin
      m_cnt = '0; m_scr = '0; m_div = 16'd868; m_ovf = 1'b0; m_busy = 1'b0;
      q.delete();
      return;
    end
    m_cnt    = m_cnt + 64'd1;
    pre_size = q.size();
    if (m_busy && (ecount - m_start == 10 * m_fdiv)) m_busy = 1'b0;
    if (!m_busy && pre_size > 0) begin
      m_byte  = q.pop_front();
      m_busy  = 1'b1;
      m_start = ecount;
      m_fdiv  = (m_div == 16'd0) ? 1 : int'(m_div);
    end
    if (!io_wrn) begin
      case (m_addr)
        12'h340: m_scr = d_t_mem;
        12'h7C1: begin m_div = d_t_mem[15:0]; m_ovf = 1'b0; end
        12'h7C0: if (pre_size < DEPTH) q.push_back(d_t_mem[7:0]); else m_ovf = 1'b1;
        default: ;
      endcase
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("txd", {31'd0, txd}, {31'd0, m_txd()});
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    io_wrn = 1'b0; m_addr = a; d_t_mem = d;
    cyc();
    io_wrn = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a);
    m_addr = a; io_rdn = 1'b1;
    #1;
    chk("rdn_idle", d_f_mem, 32'd0);
    io_rdn = 1'b0;
    #1;
    chk(tag, d_f_mem, m_rd(a));
    io_rdn = 1'b1;
  endtask

  initial begin
    logic [11:0] addrs [6];
    addrs = '{12'hC00, 12'hC80, 12'h340, 12'h7C0, 12'h7C1, 12'h123};
    clr = 1'b1; io_wrn = 1'b1; io_rdn = 1'b1; m_addr = '0; d_t_mem = '0;
    cyc(); cyc();
    rd_chk("rst_status", 12'h7C0);
    rd_chk("rst_div", 12'h7C1);
    rd_chk("rst_scratch", 12'h340);
    clr = 1'b0;
    repeat (5) cyc();
    rd_chk("cycle5", 12'hC00);
    io_rdn = 1'b0; m_addr = 12'hC00; #1;
    chk("cycle5_const", d_f_mem, 32'd5);
    io_rdn = 1'b1;
    rd_chk("cycleh0", 12'hC80);

    force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    m_cnt = 64'h0000_0000_FFFF_FFFF;
    cyc();
    rd_chk("cycleh_carry", 12'hC80);
    rd_chk("cycle_carry", 12'hC00);

    wr(12'h340, 32'hDEADBEEF);
    io_wrn = 1'b0; io_rdn = 1'b0; m_addr = 12'h340; d_t_mem = 32'h1;
    #1;
    chk("rw_old", d_f_mem, 32'hDEADBEEF);
    cyc();
    io_wrn = 1'b1;
    #1;
    chk("rw_new", d_f_mem, 32'h1);
    io_rdn = 1'b1;

    wr(12'h7C1, 32'd4);
    wr(12'h7C0, 32'hA5);
    for (int i = 0; i < 44; i++) begin
      rd_chk("a5_status", 12'h7C0);
      cyc();
    end
    rd_chk("a5_idle", 12'h7C0);

    wr(12'h7C1, 32'd2);
    for (int i = 0; i < 6; i++) wr(12'h7C0, 32'h30 + i);
    rd_chk("ovf_status", 12'h7C0);
    io_rdn = 1'b0; m_addr = 12'h7C0; #1;
    chk("ovf_status_const", d_f_mem, 32'hE);
    io_rdn = 1'b1;
    for (int i = 0; i < 30; i++) cyc();
    wr(12'h7C1, 32'd2);
    rd_chk("ovf_clear", 12'h7C0);
    for (int i = 0; i < 100; i++) cyc();
    rd_chk("drain", 12'h7C0);

    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) wr(12'h7C0, $urandom);
      else if (r == 3) wr(12'h340, $urandom);
      else if (r == 4 && !m_busy && q.size() == 0) wr(12'h7C1, $urandom_range(0, 3));
      else if (r == 5) wr(12'h123, $urandom);
      else cyc();
      rd_chk("rand_rd", addrs[$urandom_range(0, 5)]);
    end
    for (int i = 0; i < 200; i++) cyc();

    wr(12'h7C1, 32'd4);
    wr(12'h7C0, 32'h5A);
    wr(12'h7C0, 32'h11);
    repeat (10) cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("rst_txd", {31'd0, txd}, 32'd1);
    io_rdn = 1'b0;
    m_addr = 12'h7C0; #1; chk("rst_mid_status", d_f_mem, 32'h1);
    m_addr = 12'h7C1; #1; chk("rst_mid_div", d_f_mem, 32'd868);
    m_addr = 12'h123; #1; chk("unmapped", d_f_mem, 32'd0);
    io_rdn = 1'b1;
    repeat (20) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
